// File: rtl/cam_pixel_capture.sv
// ---------------------------------------------------------------------------
// cam_pixel_capture
//
// OV7670-style pixel capture front end. The camera pins are oversampled in
// the system clock domain. Bytes are packed into pixels, optionally decimated
// by 2^dec_shift in X and Y, and buffered in a FIFO. The FIFO drives a
// valid/ready stream whose beats carry source coordinates and a
// start-of-frame flag.
//
// Ports
//   clk        system clock; must run at least 4x the camera PCLK
//   rst        synchronous active-high reset
//   cam_pclk   camera pixel clock, sampled as data
//   cam_vsync  camera VSYNC (level VS_POL = blanking)
//   cam_href   camera HREF  (level HREF_POL = line active)
//   cam_data   camera data bus
//   enable     capture enable, acted on at frame boundaries
//   dec_shift  keep every 2^dec_shift pixel and line, latched at frame start
//   m_data     pixel, first byte received in the MSBs
//   m_x, m_y   source (pre-decimation) coordinates of the pixel
//   m_sof      first emitted pixel of a frame
//   m_valid    stream valid
//   m_ready    stream ready
//   frame_cnt  completed captured frames (wraps)
//   ovf_cnt    kept pixels dropped because the FIFO was full (saturates)
//   busy       capture FSM not idle
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module cam_pixel_capture #(
  parameter int   DATA_W        = 8,
  parameter int   BYTES_PER_PIX = 2,
  parameter int   COORD_W       = 10,
  parameter int   FIFO_DEPTH    = 16,
  parameter int   SYNC_STAGES   = 2,
  parameter logic VS_POL        = 1'b1,
  parameter logic HREF_POL      = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cam_pclk,
  input  logic                            cam_vsync,
  input  logic                            cam_href,
  input  logic [DATA_W-1:0]               cam_data,
  input  logic                            enable,
  input  logic [1:0]                      dec_shift,
  output logic [DATA_W*BYTES_PER_PIX-1:0] m_data,
  output logic [COORD_W-1:0]              m_x,
  output logic [COORD_W-1:0]              m_y,
  output logic                            m_sof,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [15:0]                     frame_cnt,
  output logic [15:0]                     ovf_cnt,
  output logic                            busy
);

  localparam int PIX_W = DATA_W * BYTES_PER_PIX;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int BC_W  = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SOF,
    ST_ACTIVE
  } state_t;

  typedef struct packed {
    logic               sof;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
    logic [PIX_W-1:0]   data;
  } entry_t;

  // -------------------------------------------------------------------------
  // Input synchronisers: the four camera inputs share identical chains so
  // data and HREF line up with the PCLK edge they belong to.
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] pclk_sync;
  logic [SYNC_STAGES-1:0] vsync_sync;
  logic [SYNC_STAGES-1:0] href_sync;
  logic [DATA_W-1:0]      data_sync [SYNC_STAGES];
  logic                   pclk_prev;
  logic                   href_prev;

  logic              pclk_s;
  logic              vblank;
  logic              href_act;
  logic [DATA_W-1:0] data_s;
  logic              pclk_rise;
  logic              href_rise;
  logic              href_fall;

  assign pclk_s   = pclk_sync[SYNC_STAGES-1];
  assign vblank   = (vsync_sync[SYNC_STAGES-1] == VS_POL);
  assign href_act = (href_sync[SYNC_STAGES-1] == HREF_POL);
  assign data_s   = data_sync[SYNC_STAGES-1];

  assign pclk_rise = pclk_s & ~pclk_prev;
  assign href_rise = href_act & ~href_prev;
  assign href_fall = ~href_act & href_prev;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes a shift chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      pclk_sync  <= '0;
      vsync_sync <= '0;
      href_sync  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
      pclk_prev  <= 1'b0;
      href_prev  <= 1'b0;
    end else begin
      pclk_sync    <= {pclk_sync[SYNC_STAGES-2:0], cam_pclk};
      vsync_sync   <= {vsync_sync[SYNC_STAGES-2:0], cam_vsync};
      href_sync    <= {href_sync[SYNC_STAGES-2:0], cam_href};
      data_sync[0] <= cam_data;
      for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
      pclk_prev    <= pclk_s;
      href_prev    <= href_act;
    end
  end

  // -------------------------------------------------------------------------
  // Capture FSM, line/pixel counters and the one-deep push stage.
  // -------------------------------------------------------------------------
  state_t             state;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [BC_W-1:0]    bcnt;
  logic [PIX_W-1:0]   shreg;
  logic [1:0]         dec_lat;
  logic               sof_pending;

  logic               pend_valid;
  logic [COORD_W-1:0] pend_x;
  logic [COORD_W-1:0] pend_y;
  logic [PIX_W-1:0]   pend_data;

  logic [BC_W-1:0]    bcnt_eff;
  logic [COORD_W-1:0] x_eff;
  logic [COORD_W-1:0] mask;
  logic               byte_take;
  logic               pix_done;
  logic               pix_keep;
  logic [PIX_W-1:0]   pix_word;

  logic               push_ok;

  // A line start may coincide with its first PCLK rise, so the counters
  // the byte sees are the already-cleared ones in that case.
  // NOTE: every signal driven here gets a default at the top of the block,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    bcnt_eff  = href_rise ? '0 : bcnt;
    x_eff     = href_rise ? '0 : x;
    mask      = COORD_W'((1 << dec_lat) - 1);
    byte_take = (state == ST_ACTIVE) && pclk_rise && href_act && !vblank;
    pix_done  = byte_take && (bcnt_eff == BC_W'(BYTES_PER_PIX - 1));
    pix_keep  = ((x_eff & mask) == '0) && ((y & mask) == '0);
    pix_word  = (shreg << DATA_W) | PIX_W'(data_s);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      x           <= '0;
      y           <= '0;
      bcnt        <= '0;
      shreg       <= '0;
      dec_lat     <= '0;
      sof_pending <= 1'b0;
      frame_cnt   <= '0;
      pend_valid  <= 1'b0;
      pend_x      <= '0;
      pend_y      <= '0;
      pend_data   <= '0;
    end else begin
      pend_valid <= 1'b0;
      // Only a pixel that actually lands in the FIFO consumes the SOF tag.
      if (push_ok) sof_pending <= 1'b0;

      case (state)
        ST_IDLE: begin
          // Starting only in blanking guarantees no partial frame.
          if (enable && vblank) begin
            state <= ST_WAIT_SOF;
            busy  <= 1'b1;
          end
        end

        ST_WAIT_SOF: begin
          if (!vblank) begin
            state       <= ST_ACTIVE;
            x           <= '0;
            y           <= '0;
            bcnt        <= '0;
            dec_lat     <= dec_shift;
            sof_pending <= 1'b1;
          end
        end

        ST_ACTIVE: begin
          if (vblank) begin
            frame_cnt <= frame_cnt + 1'b1;
            if (enable) begin
              state <= ST_WAIT_SOF;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end

          if (href_rise) begin
            x    <= '0;
            bcnt <= '0;
          end

          // Line end: a partially assembled pixel is simply forgotten.
          if (href_fall) begin
            y    <= y + 1'b1;
            bcnt <= '0;
          end

          if (byte_take) begin
            shreg <= pix_word;
            if (pix_done) begin
              bcnt <= '0;
              x    <= x_eff + 1'b1;
            end else begin
              bcnt <= bcnt_eff + 1'b1;
            end
          end

          if (pix_done && pix_keep) begin
            pend_valid <= 1'b1;
            pend_x     <= x_eff;
            pend_y     <= y;
            pend_data  <= pix_word;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output FIFO. A push arriving while full is accepted only if a pop
  // frees a slot on the same edge; otherwise it is counted as an overflow.
  // -------------------------------------------------------------------------
  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic   full;
  logic   pop;
  logic   drop;
  entry_t wr_entry;
  entry_t rd_entry;

  always_comb begin
    full           = (count == (AW+1)'(FIFO_DEPTH));
    pop            = m_valid && m_ready;
    push_ok        = pend_valid && (!full || pop);
    drop           = pend_valid && full && !pop;
    wr_entry.sof   = sof_pending;
    wr_entry.y     = pend_y;
    wr_entry.x     = pend_x;
    wr_entry.data  = pend_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && (ovf_cnt != 16'hFFFF)) ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the pointers and count define
  // which entries are meaningful, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_entry;
  end

  assign rd_entry = mem[rd_ptr];
  assign m_valid  = (count != '0);

  // Outputs read as zero while nothing is presented.
  assign m_data = m_valid ? rd_entry.data : '0;
  assign m_x    = m_valid ? rd_entry.x    : '0;
  assign m_y    = m_valid ? rd_entry.y    : '0;
  assign m_sof  = m_valid ? rd_entry.sof  : 1'b0;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// ---------------------------------------------------------------------------
// tb_cam_pixel_capture
//
// Drives camera frames (VSYNC/HREF/PCLK/data) into cam_pixel_capture. A
// frame-level model computes each expected output beat from the bytes sent
// and the capture rules, and queues it. A monitor pops and compares on every
// accepted beat. Counters and busy are checked at frame boundaries.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_cam_pixel_capture;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cam_pclk;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        enable;
  logic [1:0]  dec_shift;
  logic [15:0] m_data;
  logic [9:0]  m_x;
  logic [9:0]  m_y;
  logic        m_sof;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] frame_cnt;
  logic [15:0] ovf_cnt;
  logic        busy;

  always #5 clk = ~clk;

  cam_pixel_capture dut (
    .clk       (clk),
    .rst       (rst),
    .cam_pclk  (cam_pclk),
    .cam_vsync (cam_vsync),
    .cam_href  (cam_href),
    .cam_data  (cam_data),
    .enable    (enable),
    .dec_shift (dec_shift),
    .m_data    (m_data),
    .m_x       (m_x),
    .m_y       (m_y),
    .m_sof     (m_sof),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .frame_cnt (frame_cnt),
    .ovf_cnt   (ovf_cnt),
    .busy      (busy)
  );

  typedef struct packed {
    logic       sof;
    logic [9:0] y;
    logic [9:0] x;
    logic [15:0] data;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_exp;
  int    n_checks = 0;
  int    n_pass   = 0;
  int    exp_frames = 0;
  int    exp_ovf    = 0;
  int    seq_k      = 0;
  int    ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: a beat is accepted on the next rising edge when valid & ready.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_beat: got sof=%0d y=%0d x=%0d data=0x%0h, expected no beat",
                 m_sof, m_y, m_x, m_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("beat{sof,y,x,data}", {27'd0, m_sof, m_y, m_x, m_data}, {27'd0, mon_exp});
      end
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One camera PCLK period of 8 system clocks; data changes with PCLK low.
  task automatic pclk_cycle(input logic [7:0] d);
    cam_pclk = 1'b0;
    cam_data = d;
    clks(4);
    cam_pclk = 1'b1;
    clks(4);
    cam_pclk = 1'b0;
  endtask

  // Sends one frame and queues the beats the capture rules predict.
  //   odd_line : line index that carries only 3 bytes (-1: none)
  //   en_line  : line at whose start enable is set to en_val (-1: none)
  //   abort_pix: stop mid line 0 after this many pixels (-1: full frame)
  //   stall    : m_ready held low for the whole frame, FIFO empty at start
  task automatic send_frame(input int nlines, input int npix, input int dec,
                            input int odd_line, input int en_line, input logic en_val,
                            input int abort_pix, input logic stall, input logic seq_data);
    logic       cap;
    logic       sof;
    int         kept;
    int         m;
    int         nbytes;
    logic [7:0] d;
    logic [7:0] hi;
    beat_t      b_exp;
    cap  = enable;           // capture is decided during the preceding blanking
    sof  = 1'b1;
    kept = 0;
    m    = (1 << dec) - 1;
    hi   = '0;
    dec_shift = 2'(dec);
    cam_vsync = 1'b1;
    cam_href  = 1'b0;
    for (int i = 0; i < 3; i++) pclk_cycle(8'($urandom));   // ignored in blanking
    clks(6);
    cam_vsync = 1'b0;
    clks(8);
    for (int ln = 0; ln < nlines; ln++) begin
      if (ln == en_line) enable = en_val;
      if (ln == 1) dec_shift = 2'($urandom_range(0, 3));    // must be ignored
      nbytes = (ln == odd_line) ? 3 : 2 * npix;
      cam_href = 1'b1;
      for (int bi = 0; bi < nbytes; bi++) begin
        if (seq_data) begin
          d = 8'(8'h12 + 8'h22 * seq_k);
          seq_k++;
        end else begin
          d = 8'($urandom);
        end
        if (bi % 2 == 0) begin
          hi = d;
        end else if (cap && (((bi / 2) & m) == 0) && ((ln & m) == 0)) begin
          if (!stall || kept < DEPTH) begin
            b_exp.sof  = sof;
            b_exp.y    = 10'(ln);
            b_exp.x    = 10'(bi / 2);
            b_exp.data = {hi, d};
            exp_q.push_back(b_exp);
            sof = 1'b0;
          end else begin
            exp_ovf++;
          end
          kept++;
        end
        pclk_cycle(d);
        if (ln == 0 && bi == 2 * abort_pix - 1) return;
      end
      cam_href = 1'b0;
      clks(4);
      pclk_cycle(8'h00);
    end
    cam_vsync = 1'b1;
    if (cap) exp_frames++;
  endtask

  task automatic drain();
    int t;
    t = 0;
    if (ready_mode == 0) ready_mode = 2;
    while (exp_q.size() != 0 && t < 3000) begin
      clks(1);
      t++;
    end
    check("drain_remaining", exp_q.size(), 0);
    clks(3);
    check("valid_after_drain", m_valid, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    cam_pclk  = 1'b0;
    cam_vsync = 1'b1;
    cam_href  = 1'b0;
    cam_data  = '0;
    enable    = 1'b0;
    dec_shift = '0;
    clks(3);
    rst = 1'b0;
    @(negedge clk);
    check("reset_m_valid",   m_valid,   1'b0);
    check("reset_m_data",    m_data,    16'h0);
    check("reset_m_sof",     m_sof,     1'b0);
    check("reset_frame_cnt", frame_cnt, 16'h0);
    check("reset_ovf_cnt",   ovf_cnt,   16'h0);
    check("reset_busy",      busy,      1'b0);

    // Two 4x3 frames of sequential bytes, always ready.
    enable = 1'b1;
    ready_mode = 1;
    send_frame(4, 3, 0, -1, -1, 1'b0, -1, 1'b0, 1'b1);
    send_frame(4, 3, 0, -1, -1, 1'b0, -1, 1'b0, 1'b1);
    clks(10);
    check("frame_cnt_two_frames", frame_cnt, 16'(exp_frames));
    check("busy_wait_sof", busy, 1'b1);
    drain();
    check("ovf_none", ovf_cnt, 16'(exp_ovf));

    // Decimation by 2, random backpressure.
    ready_mode = 2;
    send_frame(4, 4, 1, -1, -1, 1'b0, -1, 1'b0, 1'b0);
    drain();

    // Overflow: 20-pixel line into a 16-deep FIFO with no reads.
    ready_mode = 0;
    send_frame(1, 20, 0, -1, -1, 1'b0, -1, 1'b1, 1'b0);
    clks(20);
    check("ovf_after_stall", ovf_cnt, 16'(exp_ovf));
    ready_mode = 1;
    drain();

    // Odd-length line in the middle of a frame.
    ready_mode = 2;
    send_frame(3, 3, 0, 1, -1, 1'b0, -1, 1'b0, 1'b0);
    drain();

    // Enable dropped mid-frame: the frame still completes, then idle.
    send_frame(3, 2, 0, -1, 1, 1'b0, -1, 1'b0, 1'b0);
    clks(10);
    check("busy_after_disable", busy, 1'b0);
    check("frame_cnt_after_disable", frame_cnt, 16'(exp_frames));
    drain();

    // Enable raised mid-frame: nothing until the next blanking.
    send_frame(3, 2, 0, -1, 1, 1'b1, -1, 1'b0, 1'b0);
    send_frame(2, 3, 0, -1, -1, 1'b0, -1, 1'b0, 1'b0);
    clks(10);
    check("frame_cnt_after_late_enable", frame_cnt, 16'(exp_frames));
    drain();

    // Random frames.
    for (int i = 0; i < 3; i++) begin
      send_frame($urandom_range(1, 4), $urandom_range(1, 6), $urandom_range(0, 3),
                 -1, -1, 1'b0, -1, 1'b0, 1'b0);
    end
    clks(10);
    check("frame_cnt_random", frame_cnt, 16'(exp_frames));
    drain();
    check("ovf_final", ovf_cnt, 16'(exp_ovf));

    // Reset mid-line with five pixels buffered.
    ready_mode = 0;
    send_frame(2, 8, 0, -1, -1, 1'b0, 5, 1'b1, 1'b0);
    clks(4);
    check("buffered_before_rst", m_valid, 1'b1);
    rst = 1'b1;
    clks(1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_m_valid",   m_valid,   1'b0);
    check("rst_mid_frame_cnt", frame_cnt, 16'h0);
    check("rst_mid_ovf_cnt",   ovf_cnt,   16'h0);
    check("rst_mid_busy",      busy,      1'b0);
    exp_q.delete();
    exp_frames = 0;
    exp_ovf    = 0;
    cam_href   = 1'b0;
    ready_mode = 2;
    send_frame(2, 3, 0, -1, -1, 1'b0, -1, 1'b0, 1'b0);
    clks(10);
    check("frame_cnt_after_rst", frame_cnt, 16'(exp_frames));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
